// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared controller definitions: the 3-bit state encoding driven by the
// convolution controller FSM and decoded by conv_sequencer.
// No ports (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_ALLOC         = 3'b000;
   localparam logic [STATE_W-1:0] ST_LOAD_AND_INIT = 3'b001;
   localparam logic [STATE_W-1:0] ST_CONVOLUTION   = 3'b010;
   localparam logic [STATE_W-1:0] ST_LOAD_RESULT   = 3'b011;
   localparam logic [STATE_W-1:0] ST_LOAD_ERROR    = 3'b100;
   localparam logic [STATE_W-1:0] ST_LOAD_OUTPUT   = 3'b101;
   localparam logic [STATE_W-1:0] ST_LOAD_INPUT    = 3'b110;
   localparam logic [STATE_W-1:0] ST_PC_INCREMENT  = 3'b111;

endpackage

// File: rtl/addr_gen.sv
// ---------------------------------------------------------------------------
// addr_gen
// Address adder: addr = base + offset, wrapping modulo 2^ADDR_W.
// Ports:
//   base   in  ADDR_W  base address
//   offset in  ADDR_W  offset (caller zero-extends narrower indices)
//   addr   out ADDR_W  resulting address
// ---------------------------------------------------------------------------
module addr_gen #(
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] offset,
   output logic [ADDR_W-1:0] addr
);

   // Carry out is dropped on purpose: address space wraps.
   assign addr = base + offset;

endmodule

// File: rtl/conv_sequencer.sv
// ---------------------------------------------------------------------------
// conv_sequencer
// Address and control sequencer for a convolution MAC. Holds the layer
// configuration, tracks the (stage, vector) position and the tap counter,
// and produces coefficient / sample addresses plus MAC strobes for the
// externally supplied controller FSM state.
// Ports:
//   clk, rst           clock, async active-low reset
//   en                 clock enable (low: registers hold, strobes low)
//   state              controller FSM state (ctrl_pkg encoding)
//   cfg_load           config write strobe (accepted only in ALLOC)
//   cfg_taps/stages/vectors, cfg_coef_base/data_base   config values
//   vector_pass        last tap of the vector is being accumulated
//   last_stage/last_vector  position flags for the FSM
//   coef_addr/data_addr     MAC operand addresses
//   mac_init/mac_acc        MAC clear / accumulate strobes
//   cfg_err            one-cycle pulse after a rejected config write
// ---------------------------------------------------------------------------
module conv_sequencer
   import ctrl_pkg::*;
#(
   parameter int TAP_W  = 8,
   parameter int STG_W  = 3,
   parameter int VEC_W  = 4,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [2:0]        state,
   input  logic              cfg_load,
   input  logic [TAP_W-1:0]  cfg_taps,
   input  logic [STG_W-1:0]  cfg_stages,
   input  logic [VEC_W-1:0]  cfg_vectors,
   input  logic [ADDR_W-1:0] cfg_coef_base,
   input  logic [ADDR_W-1:0] cfg_data_base,
   output logic              vector_pass,
   output logic              last_stage,
   output logic              last_vector,
   output logic [ADDR_W-1:0] coef_addr,
   output logic [ADDR_W-1:0] data_addr,
   output logic              mac_init,
   output logic              mac_acc,
   output logic              cfg_err
);

   localparam logic [TAP_W-1:0] TAP_ONE = TAP_W'(1);
   localparam logic [STG_W-1:0] STG_ONE = STG_W'(1);
   localparam logic [VEC_W-1:0] VEC_ONE = VEC_W'(1);

   // configuration
   logic [TAP_W-1:0]  taps_r;
   logic [STG_W-1:0]  stages_r;
   logic [VEC_W-1:0]  vectors_r;
   logic [ADDR_W-1:0] coef_base_r;
   logic [ADDR_W-1:0] data_base_r;

   // position
   logic [TAP_W-1:0]  tap_cnt;
   logic [STG_W-1:0]  stg_idx;
   logic [VEC_W-1:0]  vec_idx;
   logic [ADDR_W-1:0] vec_base;
   logic              cfg_err_q;

   // decode
   logic st_alloc, st_init, st_conv, st_pc;
   logic cfg_accept, cfg_reject;
   logic tap_last;

   assign st_alloc = (state == ST_ALLOC);
   assign st_init  = (state == ST_LOAD_AND_INIT);
   assign st_conv  = (state == ST_CONVOLUTION);
   assign st_pc    = (state == ST_PC_INCREMENT);

   assign cfg_accept = en & cfg_load & st_alloc;
   assign cfg_reject = en & cfg_load & ~st_alloc;

   // taps_r is never zero, so taps_r-1 cannot underflow
   assign tap_last    = (tap_cnt == taps_r - TAP_ONE);
   assign last_stage  = (stg_idx == stages_r - STG_ONE);
   assign last_vector = (vec_idx == vectors_r - VEC_ONE);

   // ------------------------------------------------------------------
   // Address arithmetic
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] vec_off;
   logic [ADDR_W-1:0] vec_base_nxt;
   logic [ADDR_W-1:0] tap_off;
   logic [ADDR_W-1:0] data_stg_base;

   // Product formed at address width so the wrap is modulo 2^ADDR_W.
   assign vec_off = ADDR_W'(vec_idx) * ADDR_W'(taps_r);

   // INIT presents tap 0 even though the counter clears only at the
   // end of the INIT cycle.
   assign tap_off = st_init ? '0 : ADDR_W'(tap_cnt);

   addr_gen #(.ADDR_W(ADDR_W)) u_vec_base (
      .base   (coef_base_r),
      .offset (vec_off),
      .addr   (vec_base_nxt)
   );

   addr_gen #(.ADDR_W(ADDR_W)) u_coef_addr (
      .base   (vec_base),
      .offset (tap_off),
      .addr   (coef_addr)
   );

   addr_gen #(.ADDR_W(ADDR_W)) u_data_stg (
      .base   (data_base_r),
      .offset (ADDR_W'(stg_idx)),
      .addr   (data_stg_base)
   );

   addr_gen #(.ADDR_W(ADDR_W)) u_data_addr (
      .base   (data_stg_base),
      .offset (tap_off),
      .addr   (data_addr)
   );

   // ------------------------------------------------------------------
   // Configuration registers; a zero count is stored as one.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taps_r      <= TAP_ONE;
         stages_r    <= STG_ONE;
         vectors_r   <= VEC_ONE;
         coef_base_r <= '0;
         data_base_r <= '0;
      end else if (cfg_accept) begin
         taps_r      <= (cfg_taps    == '0) ? TAP_ONE : cfg_taps;
         stages_r    <= (cfg_stages  == '0) ? STG_ONE : cfg_stages;
         vectors_r   <= (cfg_vectors == '0) ? VEC_ONE : cfg_vectors;
         coef_base_r <= cfg_coef_base;
         data_base_r <= cfg_data_base;
      end
   end

   // ------------------------------------------------------------------
   // Vector base: refreshed every enabled ALLOC cycle from the registered
   // config/index, so a config accepted in ALLOC needs one more ALLOC
   // cycle before INIT.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         vec_base <= '0;
      else if (en && st_alloc)
         vec_base <= vec_base_nxt;
   end

   // ------------------------------------------------------------------
   // Tap counter: cleared in INIT, counts in CONVOLUTION, saturating at
   // taps-1 (the "<" also stops it if taps shrank under a larger count).
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tap_cnt <= '0;
      else if (en) begin
         if (st_init)
            tap_cnt <= '0;
         else if (st_conv && (tap_cnt < taps_r - TAP_ONE))
            tap_cnt <= tap_cnt + TAP_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Stage / vector indices: stage is the inner loop.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_idx <= '0;
         vec_idx <= '0;
      end else if (cfg_accept) begin
         stg_idx <= '0;
         vec_idx <= '0;
      end else if (en && st_pc) begin
         if (!last_stage)
            stg_idx <= stg_idx + STG_ONE;
         else begin
            stg_idx <= '0;
            vec_idx <= last_vector ? '0 : vec_idx + VEC_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Rejected-write flag. Refreshed every cycle (not held by en) so it is
   // a single-cycle pulse; the output is additionally masked by en.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cfg_err_q <= 1'b0;
      else
         cfg_err_q <= cfg_reject;
   end

   assign cfg_err     = cfg_err_q & en;
   assign mac_init    = en & st_init;
   assign mac_acc     = en & st_conv;
   assign vector_pass = st_conv & tap_last;

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;
   localparam int TAP_W  = 8;
   localparam int STG_W  = 3;
   localparam int VEC_W  = 4;
   localparam int ADDR_W = 10;
   localparam int AMOD   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic [2:0]        state = 3'd0;
   logic              cfg_load = 1'b0;
   logic [TAP_W-1:0]  cfg_taps = '0;
   logic [STG_W-1:0]  cfg_stages = '0;
   logic [VEC_W-1:0]  cfg_vectors = '0;
   logic [ADDR_W-1:0] cfg_coef_base = '0;
   logic [ADDR_W-1:0] cfg_data_base = '0;
   logic              vector_pass, last_stage, last_vector;
   logic [ADDR_W-1:0] coef_addr, data_addr;
   logic              mac_init, mac_acc, cfg_err;

   always #5 clk = ~clk;

   conv_sequencer #(.TAP_W(TAP_W), .STG_W(STG_W), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .en(en), .state(state), .cfg_load(cfg_load),
      .cfg_taps(cfg_taps), .cfg_stages(cfg_stages), .cfg_vectors(cfg_vectors),
      .cfg_coef_base(cfg_coef_base), .cfg_data_base(cfg_data_base),
      .vector_pass(vector_pass), .last_stage(last_stage), .last_vector(last_vector),
      .coef_addr(coef_addr), .data_addr(data_addr),
      .mac_init(mac_init), .mac_acc(mac_acc), .cfg_err(cfg_err));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_taps, m_stages, m_vectors, m_cbase, m_dbase;
   int m_stg, m_vec, m_tap, m_vbase;
   bit m_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_taps <= 1; m_stages <= 1; m_vectors <= 1; m_cbase <= 0; m_dbase <= 0;
         m_stg <= 0; m_vec <= 0; m_tap <= 0; m_vbase <= 0; m_err <= 0;
      end else begin
         m_err <= en && cfg_load && state != 3'd0;
         if (en) begin
            if (state == 3'd0) m_vbase <= (m_cbase + m_vec * m_taps) % AMOD;
            if (state == 3'd0 && cfg_load) begin
               m_taps    <= (cfg_taps == 0) ? 1 : int'(cfg_taps);
               m_stages  <= (cfg_stages == 0) ? 1 : int'(cfg_stages);
               m_vectors <= (cfg_vectors == 0) ? 1 : int'(cfg_vectors);
               m_cbase   <= int'(cfg_coef_base);
               m_dbase   <= int'(cfg_data_base);
               m_stg <= 0; m_vec <= 0;
            end
            if (state == 3'd1) m_tap <= 0;
            if (state == 3'd2 && m_tap < m_taps - 1) m_tap <= m_tap + 1;
            if (state == 3'd7) begin
               if (m_stg == m_stages - 1) begin
                  m_stg <= 0;
                  m_vec <= (m_vec == m_vectors - 1) ? 0 : m_vec + 1;
               end else
                  m_stg <= m_stg + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : cmp
      int off;
      off = (state == 3'd1) ? 0 : m_tap;
      chk("vector_pass", 32'(vector_pass), 32'(state == 3'd2 && m_tap == m_taps - 1));
      chk("last_stage",  32'(last_stage),  32'(m_stg == m_stages - 1));
      chk("last_vector", 32'(last_vector), 32'(m_vec == m_vectors - 1));
      chk("coef_addr",   32'(coef_addr),   32'((m_vbase + off) % AMOD));
      chk("data_addr",   32'(data_addr),   32'((m_dbase + m_stg + off) % AMOD));
      chk("mac_init",    32'(mac_init),    32'(en && state == 3'd1));
      chk("mac_acc",     32'(mac_acc),     32'(en && state == 3'd2));
      chk("cfg_err",     32'(cfg_err),     32'(m_err && en));
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [2:0] st, input logic e, input logic ld);
      @(posedge clk); #1;
      state = st; en = e; cfg_load = ld;
      @(negedge clk);
   endtask

   task automatic setcfg(input int t, input int s, input int v, input int cb, input int db);
      cfg_taps = TAP_W'(t); cfg_stages = STG_W'(s); cfg_vectors = VEC_W'(v);
      cfg_coef_base = ADDR_W'(cb); cfg_data_base = ADDR_W'(db);
   endtask

   int exp_ls[6] = '{0, 1, 0, 0, 1, 0};
   int exp_lv[6] = '{0, 0, 1, 1, 1, 0};
   int exp_st[6] = '{1, 2, 0, 1, 2, 0};

   initial begin
      // reset state
      #12;
      chk("rst_coef", 32'(coef_addr), 0);
      chk("rst_data", 32'(data_addr), 0);
      chk("rst_last_stage", 32'(last_stage), 1);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      @(posedge clk); #1 rst = 1'b1;

      // taps=4 vector walk
      setcfg(4, 3, 2, 0, 100);
      drive(3'd0, 1, 1);
      drive(3'd0, 1, 0);
      drive(3'd1, 1, 0);
      chk("init_mac_init", 32'(mac_init), 1);
      chk("init_coef", 32'(coef_addr), 0);
      for (int k = 0; k < 4; k++) begin
         drive(3'd2, 1, 0);
         chk("conv_coef", 32'(coef_addr), 32'(k));
         chk("conv_data", 32'(data_addr), 32'(100 + k));
         chk("conv_mac_acc", 32'(mac_acc), 1);
         chk("conv_vpass", 32'(vector_pass), 32'(k == 3));
      end

      // stage/vector stepping (tap saturated at 3)
      for (int k = 0; k < 6; k++) begin
         drive(3'd7, 1, 0);
         drive(3'd3, 1, 0);
         chk("pc_last_stage", 32'(last_stage), 32'(exp_ls[k]));
         chk("pc_last_vector", 32'(last_vector), 32'(exp_lv[k]));
         chk("pc_data", 32'(data_addr), 32'(100 + exp_st[k] + 3));
      end

      // rejected write during convolution
      setcfg(9, 5, 5, 77, 11);
      drive(3'd2, 1, 1);
      drive(3'd3, 1, 0);
      chk("err_pulse", 32'(cfg_err), 1);
      drive(3'd3, 1, 0);
      chk("err_clear", 32'(cfg_err), 0);
      drive(3'd0, 1, 0);
      drive(3'd1, 1, 0);
      for (int k = 0; k < 4; k++) begin
         drive(3'd2, 1, 0);
         chk("keep_vpass", 32'(vector_pass), 32'(k == 3));
      end

      // zero taps behaves as one
      setcfg(0, 1, 1, 5, 0);
      drive(3'd0, 1, 1);
      drive(3'd0, 1, 0);
      drive(3'd1, 1, 0);
      drive(3'd2, 1, 0);
      chk("taps0_vpass", 32'(vector_pass), 1);
      chk("taps0_coef", 32'(coef_addr), 5);

      // enable stall mid-convolution
      setcfg(4, 1, 1, 40, 0);
      drive(3'd0, 1, 1);
      drive(3'd0, 1, 0);
      drive(3'd1, 1, 0);
      drive(3'd2, 1, 0);
      drive(3'd2, 1, 0);
      chk("stall_pre", 32'(coef_addr), 41);
      for (int k = 0; k < 3; k++) begin
         drive(3'd2, 0, 0);
         chk("stall_coef", 32'(coef_addr), 42);
         chk("stall_acc", 32'(mac_acc), 0);
      end
      drive(3'd2, 1, 0);
      chk("resume_coef", 32'(coef_addr), 42);
      chk("resume_vpass", 32'(vector_pass), 0);
      drive(3'd2, 1, 0);
      chk("resume_last", 32'(coef_addr), 43);
      chk("resume_vpass2", 32'(vector_pass), 1);

      // reset in the middle of a vector
      setcfg(4, 3, 2, 8, 20);
      drive(3'd0, 1, 1);
      drive(3'd0, 1, 0);
      drive(3'd1, 1, 0);
      drive(3'd2, 1, 0);
      drive(3'd2, 1, 0);
      @(posedge clk); #1;
      state = 3'd2;
      #2 rst = 1'b0;
      #1;
      chk("arst_coef", 32'(coef_addr), 0);
      chk("arst_data", 32'(data_addr), 0);
      chk("arst_err", 32'(cfg_err), 0);
      @(posedge clk); #1 rst = 1'b1;
      drive(3'd0, 1, 0);
      drive(3'd0, 1, 0);
      drive(3'd1, 1, 0);
      chk("post_rst_data", 32'(data_addr), 0);
      chk("post_rst_ls", 32'(last_stage), 1);
      drive(3'd2, 1, 0);
      chk("post_rst_vpass", 32'(vector_pass), 1);

      // randomized traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         state = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) state = 3'd2;
         en = ($urandom_range(0, 9) != 0);
         cfg_load = ($urandom_range(0, 14) == 0);
         cfg_taps = TAP_W'($urandom_range(0, 9));
         cfg_stages = STG_W'($urandom);
         cfg_vectors = VEC_W'($urandom);
         cfg_coef_base = ADDR_W'($urandom);
         cfg_data_base = ADDR_W'($urandom);
      end
      @(posedge clk); #1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
